// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, status bit positions and FSM states
// for the handshaked sequential ALU core.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_INC = 4'b0010;
    localparam logic [3:0] OP_TFR = 4'b0011;
    localparam logic [3:0] OP_NEG = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_NOT = 4'b1010;
    localparam logic [3:0] OP_XOR = 4'b1011;
    localparam logic [3:0] OP_SHL = 4'b1100;
    localparam logic [3:0] OP_SHR = 4'b1101;
    localparam logic [3:0] OP_MUL = 4'b1110;

    localparam int ST_V = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_N = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] pack_st(
        input logic v,
        input logic z,
        input logic c,
        input logic n
    );
        logic [3:0] s;
        s       = '0;
        s[ST_V] = v;
        s[ST_Z] = z;
        s[ST_C] = c;
        s[ST_N] = n;
        return s;
    endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// alu_comb_unit: single-cycle datapath and flags for all ops that
// finish on the accept edge (shifts here only cover n == 0).
module alu_comb_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             arith;
    logic [WIDTH:0]   sum;
    logic             v;
    logic             c;

    // One shared adder; the arithmetic ops only differ in operands and cin.
    always_comb begin
        x     = a;
        y     = '0;
        cin   = 1'b0;
        arith = 1'b1;
        unique case (opcode)
            OP_ADD: y = b;
            OP_SUB: begin
                y   = ~b;
                cin = 1'b1;
            end
            OP_INC: cin = 1'b1;
            OP_TFR: y = '0;
            OP_NEG: begin
                x   = ~a;
                cin = 1'b1;
            end
            default: arith = 1'b0;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    end

    // Result select and flag generation; unknown codes fall to zero.
    always_comb begin
        unique case (opcode)
            OP_AND:          result = a & b;
            OP_OR:           result = a | b;
            OP_NOT:          result = ~a;
            OP_XOR:          result = a ^ b;
            OP_SHL, OP_SHR:  result = a;
            default:         result = arith ? sum[WIDTH-1:0] : '0;
        endcase
        c = arith & sum[WIDTH];
        v = arith & (x[WIDTH-1] == y[WIDTH-1])
                  & (sum[WIDTH-1] != x[WIDTH-1]);
        status = pack_st(v, ~|result, c, result[WIDTH-1]);
    end

endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: valid/ready ALU with bit-serial shifts and optional
// shift-add multiply, enabled by defining ALU_MUL_EN.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] c_res;
    logic [3:0]       c_st;
    logic             shift_req;
    logic             last_step;
    logic [WIDTH-1:0] sh_nxt;
    logic             sh_out;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc_nxt;
`endif

    alu_comb_unit #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .result (c_res),
        .status (c_st)
    );

    assign shift_req = ((opcode == OP_SHL) || (opcode == OP_SHR))
                       && (|b[SW-1:0]);
    assign last_step = (cnt == CW'(1));

    // One-bit shift step and the bit it pushes out.
    always_comb begin
        if (op_q == OP_SHL) begin
            sh_nxt = {sh_q[WIDTH-2:0], 1'b0};
            sh_out = sh_q[WIDTH-1];
        end else begin
            sh_nxt = {1'b0, sh_q[WIDTH-1:1]};
            sh_out = sh_q[0];
        end
    end

`ifdef ALU_MUL_EN
    // Conditional add of the shifted multiplicand.
    always_comb begin
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
    end
`endif

    // Control FSM with registered handshake, status and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            result    <= '0;
            status    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= opcode;
                        in_ready <= 1'b0;
                        if (shift_req) begin
                            sh_q  <= a;
                            cnt   <= CW'(b[SW-1:0]);
                            busy  <= 1'b1;
                            state <= EXEC;
                        end
`ifdef ALU_MUL_EN
                        else if (opcode == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            cnt    <= CW'(WIDTH);
                            busy   <= 1'b1;
                            state  <= EXEC;
                        end
`endif
                        else begin
                            result    <= c_res;
                            status    <= c_st;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt - CW'(1);
`ifdef ALU_MUL_EN
                    if (op_q == OP_MUL) begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        if (last_step) begin
                            result    <= acc_nxt[WIDTH-1:0];
                            status    <= pack_st(1'b0,
                                                 ~|acc_nxt[WIDTH-1:0],
                                                 |acc_nxt[2*WIDTH-1:WIDTH],
                                                 acc_nxt[WIDTH-1]);
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else
`endif
                    begin
                        sh_q <= sh_nxt;
                        if (last_step) begin
                            result    <= sh_nxt;
                            status    <= pack_st(1'b0, ~|sh_nxt,
                                                 sh_out,
                                                 sh_nxt[WIDTH-1]);
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: random and directed stimulus checked every cycle
// against an arithmetic reference model of the ALU.
module tb_alu_seq_core;

    typedef struct {
        logic [7:0] r;
        logic [3:0] st;
        int         lat;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] opcode = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic [3:0] status;
    logic       busy;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_acc = 0;
    bit   mon_en = 1'b0;
    int   rdy_mode = 0;
    exp_t q[$];
    int   acc_log[$];
    exp_t e;
    exp_t pe;
    int   el;

    alu_seq_core #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .status    (status),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op,
                                   input logic [7:0] av,
                                   input logic [7:0] bv);
        exp_t x;
        int   ua = int'(av);
        int   ub = int'(bv);
        int   sa = int'($signed(av));
        int   sb = int'($signed(bv));
        int   n  = int'(bv[2:0]);
        int   s;
        logic v = 1'b0;
        logic c = 1'b0;
        logic [7:0] r = '0;
        x.lat = 1;
        x.acc = 0;
        case (op)
            4'h0: begin
                r = 8'(ua + ub); c = (ua + ub) > 255;
                s = sa + sb; v = (s > 127) || (s < -128);
            end
            4'h1: begin
                r = 8'(ua - ub); c = (ua >= ub);
                s = sa - sb; v = (s > 127) || (s < -128);
            end
            4'h2: begin
                r = 8'(ua + 1); c = (ua == 255); v = (sa + 1 > 127);
            end
            4'h3: r = av;
            4'h4: begin
                r = 8'(0 - ua); c = (ua == 0); v = (-sa > 127);
            end
            4'h8: r = av & bv;
            4'h9: r = av | bv;
            4'hA: r = ~av;
            4'hB: r = av ^ bv;
            4'hC: begin
                r = 8'(ua << n); c = ((ua << n) & 256) != 0;
                x.lat = (n != 0) ? n + 1 : 1;
            end
            4'hD: begin
                r = 8'(ua >> n);
                c = (n != 0) && (((ua >> (n - 1)) & 1) != 0);
                x.lat = (n != 0) ? n + 1 : 1;
            end
`ifdef ALU_MUL_EN
            4'hE: begin
                r = 8'(ua * ub); c = (ua * ub) > 255; x.lat = 9;
            end
`endif
            default: r = '0;
        endcase
        x.r  = r;
        x.st = {v, (r == 8'h00), c, r[7]};
        return x;
    endfunction

    // Compare process: every cycle, outputs vs. the pending model item.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (q.size() != 0) begin
                el = cyc - q[0].acc + 1;
                chk("out_valid", int'(out_valid), int'(el >= q[0].lat));
                chk("busy", int'(busy), int'(el < q[0].lat));
                chk("in_ready_busy", int'(in_ready), 0);
                if (out_valid && el >= q[0].lat) begin
                    chk("result", int'(result), int'(q[0].r));
                    chk("status", int'(status), int'(q[0].st));
                    if (out_ready) void'(q.pop_front());
                end
            end else begin
                chk("idle_out_valid", int'(out_valid), 0);
                chk("idle_busy", int'(busy), 0);
                chk("idle_in_ready", int'(in_ready), 1);
                if (in_valid && in_ready) begin
                    e = model(opcode, a, b);
                    e.acc = cyc + 1;
                    q.push_back(e);
                    acc_log.push_back(cyc + 1);
                    n_acc++;
                end
            end
        end
    end

    // Consumer back-pressure: 0 hold, 1 always ready, 2 random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_result", int'(result), 0);
        chk("rst_status", int'(status), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        #1;
        rst_n = 1'b1;
        q.delete();
        mon_en = 1'b1;
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] av,
                        input logic [7:0] bv);
        int k = n_acc;
        int t = 0;
        opcode = op;
        a = av;
        b = bv;
        in_valid = 1'b1;
        while (n_acc == k && t < 60) begin
            @(posedge clk);
            t++;
        end
        if (n_acc == k) chk("accept_timeout", 0, 1);
        #2;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        opcode = 4'($urandom);
    endtask

    task automatic wait_valid();
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("wait_valid", int'(out_valid), 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (q.size() != 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        chk("drain", q.size(), 0);
        #2;
    endtask

    task automatic release_out();
        @(posedge clk);
        #2;
        rdy_mode = 1;
        wait_idle();
        rdy_mode = 0;
    endtask

    task automatic dut_lit(input string nm, input logic [7:0] r,
                           input logic [3:0] st);
        chk({nm, "_result"}, int'(result), int'(r));
        chk({nm, "_status"}, int'(status), int'(st));
    endtask

    initial begin
        do_reset();

        pe = model(4'h0, 8'h7F, 8'h01);
        chk("model_add", int'({pe.r, pe.st}), 12'h809);
        pe = model(4'h1, 8'h05, 8'h05);
        chk("model_sub", int'({pe.r, pe.st}), 12'h006);
        pe = model(4'hC, 8'h81, 8'h03);
        chk("model_shl", int'({pe.r, pe.st}), 12'h080);
        chk("model_shl_lat", pe.lat, 4);
        pe = model(4'hD, 8'h81, 8'h01);
        chk("model_shr", int'({pe.r, pe.st}), 12'h402);
        pe = model(4'h4, 8'h80, 8'h00);
        chk("model_neg", int'({pe.r, pe.st}), 12'h809);
        pe = model(4'h7, 8'hFF, 8'h00);
        chk("model_ill", int'({pe.r, pe.st}), 12'h004);

        rdy_mode = 0;
        send(4'h0, 8'h7F, 8'h01);
        wait_valid();
        dut_lit("add", 8'h80, 4'b1001);
        release_out();

        send(4'h1, 8'h05, 8'h05);
        wait_valid();
        dut_lit("sub", 8'h00, 4'b0110);
        repeat (5) @(negedge clk);
        dut_lit("sub_hold", 8'h00, 4'b0110);
        chk("hold_out_valid", int'(out_valid), 1);
        chk("hold_in_ready", int'(in_ready), 0);
        release_out();

        send(4'hC, 8'h81, 8'h03);
        wait_valid();
        dut_lit("shl", 8'h08, 4'b0000);
        release_out();

        send(4'hD, 8'h81, 8'h01);
        wait_valid();
        dut_lit("shr", 8'h40, 4'b0010);
        release_out();

        send(4'h7, 8'hFF, 8'h00);
        wait_valid();
        dut_lit("illegal", 8'h00, 4'b0100);
        release_out();

        send(4'hE, 8'h10, 8'h11);
        wait_valid();
`ifdef ALU_MUL_EN
        dut_lit("mul", 8'h10, 4'b0010);
`else
        dut_lit("mul_off", 8'h00, 4'b0100);
`endif
        release_out();

        send(4'h3, 8'h5A, 8'h00);
        release_out();
        send(4'hC, 8'hFF, 8'h07);
        repeat (2) @(posedge clk);
        do_reset();
`ifdef ALU_MUL_EN
        send(4'h3, 8'h5A, 8'h00);
        release_out();
        send(4'hE, 8'hFF, 8'hFF);
        repeat (2) @(posedge clk);
        do_reset();
`endif

        rdy_mode = 1;
        @(posedge clk);
        #2;
        acc_log.delete();
        for (int i = 0; i < 4; i++)
            send(4'h8 + 4'(i), 8'($urandom), 8'($urandom));
        wait_idle();
        for (int i = 1; i < 4; i++)
            chk("b2b_spacing", acc_log[i] - acc_log[i-1], 2);

        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send(4'($urandom), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #2;
            end
        end
        rdy_mode = 1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
